// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational one-bit full adder used by the serial adder datapath.
module fa_cell (
  output logic cout,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: operands are shifted LSB-first through one full-adder cell,
// with start/busy/done handshake and a result held until the next accepted start.
module serial_adder_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;

  fa_cell u_fa (
    .cout (fa_cout),
    .sum  (fa_sum),
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry)
  );

  // Sum bits enter at the MSB so that after WIDTH steps the LSB is at bit 0.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign s_nxt = fa_sum;
    end else begin : g_wide
      assign s_nxt = {fa_sum, s_sh[WIDTH-1:1]};
    end
  endgenerate

  assign busy = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_nxt;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          // Result registers take the final bit directly from the cell on the last step.
          if (cnt == LAST) begin
            state   <= S_DONE;
            done    <= 1'b1;
            sum_out <= s_nxt;
            cout    <= fa_cout;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int passed = 0;
  int total  = 0;
  logic [7:0] prev_s8 = '0;
  logic       prev_c8 = 1'b0;
  logic [0:0] prev_s1 = '0;
  logic       prev_c1 = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] es, input logic ec);
    int lat;
    bit ov, st;
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    tick;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    chk({tag, " busy"}, 32'(busy8), 32'd1);
    lat = 0; ov = 0; st = 1;
    while (!done8 && lat < 40) begin
      ov |= busy8 & done8;
      if (sum8 !== prev_s8 || cout8 !== prev_c8) st = 0;
      tick;
      lat++;
    end
    ov |= busy8 & done8;
    chk({tag, " latency"}, 32'(lat), 32'd8);
    chk({tag, " sum"}, 32'(sum8), 32'(es));
    chk({tag, " cout"}, 32'(cout8), 32'(ec));
    chk({tag, " busy&done"}, 32'(ov), 32'd0);
    chk({tag, " held"}, 32'(st), 32'd1);
    tick;
    chk({tag, " pulse"}, 32'(done8), 32'd0);
    prev_s8 = es; prev_c8 = ec;
  endtask

  task automatic run1(input string tag, input logic [0:0] a, input logic [0:0] b,
                      input logic c, input logic [0:0] es, input logic ec);
    int lat;
    bit st;
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    tick;
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    chk({tag, " busy"}, 32'(busy1), 32'd1);
    lat = 0; st = 1;
    while (!done1 && lat < 20) begin
      if (sum1 !== prev_s1 || cout1 !== prev_c1) st = 0;
      tick;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd1);
    chk({tag, " sum"}, 32'(sum1), 32'(es));
    chk({tag, " cout"}, 32'(cout1), 32'(ec));
    chk({tag, " busy&done"}, 32'(busy1 & done1), 32'd0);
    chk({tag, " held"}, 32'(st), 32'd1);
    tick;
    chk({tag, " pulse"}, 32'(done1), 32'd0);
    prev_s1 = es; prev_c1 = ec;
  endtask

  initial begin
    int ndone, last;
    bit seen;
    logic [7:0] ra, rb, es;
    logic       rc, ec;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset sum", 32'(sum8), 32'd0);
    chk("reset cout", 32'(cout8), 32'd0);
    chk("reset1 sum", 32'(sum1), 32'd0);
    chk("reset1 busy", 32'(busy1), 32'd0);

    run8("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("t2b", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

    // Start held high: one result per WIDTH+2 cycles, operands scrambled while busy.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    ndone = 0; last = 0;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (busy8) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end else begin
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
      end
      if (done8) begin
        ndone++;
        chk("t3 sum", 32'(sum8), 32'h30);
        chk("t3 cout", 32'(cout8), 32'd0);
        if (last > 0) chk("t3 interval", 32'(i - last), 32'd10);
        last = i;
      end
    end
    chk("t3 done count", 32'(ndone), 32'd3);
    start8 = 1'b0;
    tick;
    prev_s8 = 8'h30; prev_c8 = 1'b0;

    // Reset during the fourth RUN cycle.
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
    tick;
    start8 = 1'b0;
    tick; tick; tick;
    chk("t4 busy before rst", 32'(busy8), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t4 busy", 32'(busy8), 32'd0);
    chk("t4 done", 32'(done8), 32'd0);
    chk("t4 sum", 32'(sum8), 32'd0);
    chk("t4 cout", 32'(cout8), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      seen |= done8 | busy8;
    end
    chk("t4 no done", 32'(seen), 32'd0);
    prev_s8 = '0; prev_c8 = 1'b0;
    prev_s1 = '0; prev_c1 = 1'b0;

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      {ec, es} = 9'(ra) + 9'(rb) + 9'(rc);
      run8("rand", ra, rb, rc, es, ec);
    end

    run1("w1 t1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run1("w1 t2a", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run1("w1 t2b", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run1("w1 full", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    start1 = 1'b1; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    tick;
    start1 = 1'b0;
    chk("w1 t4 busy before rst", 32'(busy1), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("w1 t4 busy", 32'(busy1), 32'd0);
    chk("w1 t4 done", 32'(done1), 32'd0);
    chk("w1 t4 sum", 32'(sum1), 32'd0);
    chk("w1 t4 cout", 32'(cout1), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen |= done1 | busy1;
    end
    chk("w1 t4 no done", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
